// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit, bundled
// so that the unit, its requester and the memory model share one port list.
interface load_store_unit_if #(
  parameter int addrW = 16
);
  // Handshake: req and its fields are sampled only on a rising edge where busy=0.
  // A sampled req either starts an access (busy rises the next cycle) or is
  // rejected as illegal/misaligned. Every sampled req ends in exactly one
  // single-cycle done pulse, with fault qualified by done. A req seen while
  // busy=1 is dropped. A new req may be presented in the done cycle itself.
  logic              req;
  logic              isStore;
  logic [2:0]        funct3;
  logic [addrW+1:0]  byteAddr;
  logic [31:0]       storeData;
  logic              busy;
  logic              done;
  logic              fault;
  logic [31:0]       loadData;
  logic [addrW-1:0]  memAddr;
  logic [31:0]       memDataW;
  logic              memRW;
  logic [31:0]       memDataR;
  logic [2:0]        fsm_state;

  modport master (
    output req, isStore, funct3, byteAddr, storeData, memDataR,
    input  busy, done, fault, loadData, memAddr, memDataW, memRW, fsm_state
  );

  modport slave (
    input  req, isStore, funct3, byteAddr, storeData, memDataR,
    output busy, done, fault, loadData, memAddr, memDataW, memRW, fsm_state
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word loads with extension, word stores,
// and read-modify-write for byte/half stores against a synchronous-read memory.
module load_store_unit #(
  parameter int addrW = 16
) (
  input logic              sysCLK,
  input logic              resetN,
  load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MRG  = 3'd2,
    DAT  = 3'd3,
    WR   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic [15:0]       store_q;
  logic [addrW-1:0]  mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       load_q;
  logic              done_q;
  logic              fault_q;

  logic              legal;
  logic              aligned;
  logic              accept_ok;
  logic              is_sw;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  // Request decode works on the live inputs because it is only used in IDLE.
  always_comb begin
    legal = 1'b0;
    if (bus.isStore) begin
      legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010);
    end else begin
      case (bus.funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end
    case (bus.funct3[1:0])
      2'b01:   aligned = ~bus.byteAddr[0];
      2'b10:   aligned = (bus.byteAddr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign accept_ok = legal && aligned;
  assign is_sw     = bus.isStore && (bus.funct3 == 3'b010);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req && accept_ok) state_nxt = is_sw ? WR : RD;
      RD:      state_nxt = is_store_q ? MRG : DAT;
      MRG:     state_nxt = WR;
      DAT:     state_nxt = IDLE;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysCLK or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Lane extraction and insertion on the word returned by memory.
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = bus.memDataR[7:0];
      2'd1:    byte_sel = bus.memDataR[15:8];
      2'd2:    byte_sel = bus.memDataR[23:16];
      default: byte_sel = bus.memDataR[31:24];
    endcase
    half_sel = lane_q[1] ? bus.memDataR[31:16] : bus.memDataR[15:0];

    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = bus.memDataR;
    endcase

    merged = bus.memDataR;
    if (funct3_q[0]) begin
      if (lane_q[1]) merged[31:16] = store_q;
      else           merged[15:0]  = store_q;
    end else begin
      case (lane_q)
        2'd0:    merged[7:0]   = store_q[7:0];
        2'd1:    merged[15:8]  = store_q[7:0];
        2'd2:    merged[23:16] = store_q[7:0];
        default: merged[31:24] = store_q[7:0];
      endcase
    end
  end

  always_ff @(posedge sysCLK or negedge resetN) begin
    if (!resetN) begin
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      store_q     <= 16'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      load_q      <= 32'h0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            if (accept_ok) begin
              is_store_q <= bus.isStore;
              funct3_q   <= bus.funct3;
              lane_q     <= bus.byteAddr[1:0];
              store_q    <= bus.storeData[15:0];
              mem_addr_q <= bus.byteAddr[addrW+1:2];
              if (is_sw) mem_wdata_q <= bus.storeData;
            end else begin
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end
          end
        end
        MRG: mem_wdata_q <= merged;
        DAT: begin
          load_q <= load_ext;
          done_q <= 1'b1;
        end
        WR:      done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;
  assign bus.loadData  = load_q;
  assign bus.memAddr   = mem_addr_q;
  assign bus.memDataW  = mem_wdata_q;
  assign bus.memRW     = (state == WR);
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random accesses checked
// against a word-array reference of memory and loadData.
module tb_load_store_unit;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.addrW(AW)) bus();

  load_store_unit #(.addrW(AW)) dut (
    .sysCLK (clk),
    .resetN (rst_n),
    .bus    (bus)
  );

  // Synchronous-read data memory seen by the DUT
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.memRW) mem[bus.memAddr] <= bus.memDataW;
    bus.memDataR <= mem[bus.memAddr];
  end

  // Reference state
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_q[$];
  logic [31:0] exp_load = 32'h0;
  logic [31:0] exp_memw = 32'h0;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check_eq("done_idle", bus.done, 1'b0);
      check_eq("memrw_idle", bus.memRW, 1'b0);
    end
  endtask

  // Must be called at a negedge with the DUT idle. Returns at the negedge of the done cycle.
  task automatic do_access(input logic st, input logic [2:0] f3, input logic [17:0] a,
                           input logic [31:0] d, input bit poke);
    bit          ok, seen;
    int          sz, lane, widx, exp_lat, exp_wr, cyc, wr_cnt;
    logic [31:0] word, lv, mask, exp_word, got_w;

    widx = int'(a >> 2);
    lane = int'(a % 4);
    sz   = 1 << f3[1:0];
    ok   = (st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) && ((a % sz) == 0);
    word = ref_mem[widx];
    exp_word = 32'h0;
    got_w    = 32'h0;

    if (!ok) begin
      exp_lat = 1; exp_wr = 0;
    end else if (!st) begin
      exp_lat = 3; exp_wr = 0;
      lv = word >> (8 * lane);
      case (f3)
        3'd0: begin lv = lv & 32'hFF;   if (lv >= 128)   lv = lv - 256;   end
        3'd1: begin lv = lv & 32'hFFFF; if (lv >= 32768) lv = lv - 65536; end
        3'd4: lv = lv & 32'hFF;
        3'd5: lv = lv & 32'hFFFF;
        default: lv = word;
      endcase
      exp_q.push_back(lv);
    end else begin
      exp_lat = (f3 == 3'd2) ? 2 : 4;
      exp_wr  = 1;
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 1);
      exp_word = (word & ~(mask << (8 * lane))) | ((d & mask) << (8 * lane));
    end

    check_eq("busy_before", bus.busy, 1'b0);
    bus.req = 1'b1; bus.isStore = st; bus.funct3 = f3; bus.byteAddr = a; bus.storeData = d;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    bus.isStore = 1'($urandom); bus.funct3 = 3'($urandom);
    bus.byteAddr = 18'($urandom); bus.storeData = $urandom;

    cyc = 0; wr_cnt = 0; seen = 0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      bus.req = 1'b0;
      if (cyc == 1 && exp_lat > 1) begin
        check_eq("mem_addr", bus.memAddr, 32'(widx));
        check_eq("busy", bus.busy, 1'b1);
        if (poke) bus.req = 1'b1;
      end
      if (bus.memRW) begin
        wr_cnt++;
        got_w = bus.memDataW;
      end
      if (bus.done) seen = 1;
    end
    bus.req = 1'b0;

    check_eq("latency", seen ? 32'(cyc) : 32'd99, 32'(exp_lat));
    check_eq("fault", bus.fault, (exp_lat == 1) ? 32'd1 : 32'd0);
    check_eq("writes", 32'(wr_cnt), 32'(exp_wr));
    if (exp_wr != 0) begin
      check_eq("wr_data", got_w, exp_word);
      ref_mem[widx] = exp_word;
      exp_memw = exp_word;
    end
    if (ok && !st && exp_q.size() > 0) exp_load = exp_q.pop_front();
    check_eq("load_data", bus.loadData, exp_load);
    check_eq("mem_data_w", bus.memDataW, exp_memw);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_wr;
    int n;
    logic [31:0] sh_old;

    bus.req = 1'b0; bus.isStore = 1'b0; bus.funct3 = 3'b0; bus.byteAddr = '0; bus.storeData = 32'h0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      mem[i] = ref_mem[i];
    end
    ref_mem[0] = 32'h80FF_1234; mem[0] = 32'h80FF_1234;
    ref_mem[1] = 32'h1122_3344; mem[1] = 32'h1122_3344;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_fault", bus.fault, 1'b0);
    check_eq("rst_load", bus.loadData, 32'h0);
    check_eq("rst_addr", bus.memAddr, 32'h0);
    check_eq("rst_memw", bus.memDataW, 32'h0);
    check_eq("rst_memrw", bus.memRW, 1'b0);
    rst_n = 1'b1;

    // Sign- and zero-extended byte loads, accepted at the first edge after reset
    do_access(1'b0, 3'b000, 18'h0003, 32'h0, 1'b0);
    check_eq("lb_0003", bus.loadData, 32'hFFFF_FF80);
    idle(1);
    do_access(1'b0, 3'b100, 18'h0003, 32'h0, 1'b0);
    check_eq("lbu_0003", bus.loadData, 32'h0000_0080);
    idle(1);

    // Byte store via read-modify-write
    do_access(1'b1, 3'b000, 18'h0005, 32'h0000_00AB, 1'b0);
    idle(1);
    check_eq("sb_mem", mem[1], 32'h1122_AB44);

    // Misaligned accesses fault without touching memory or loadData
    do_access(1'b0, 3'b001, 18'h0001, 32'h0, 1'b0);
    idle(1);
    do_access(1'b1, 3'b010, 18'h0006, 32'h1234_5678, 1'b0);
    check_eq("fault_keep_load", bus.loadData, 32'h0000_0080);
    idle(1);

    // Word store then back-to-back word load, with a req poked while busy
    do_access(1'b1, 3'b010, 18'h0008, 32'hDEAD_BEEF, 1'b1);
    do_access(1'b0, 3'b010, 18'h0008, 32'h0, 1'b1);
    check_eq("sw_lw", bus.loadData, 32'hDEAD_BEEF);
    idle(1);

    // Random traffic over a small region so stores and loads overlap
    for (int i = 0; i < 150; i++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                      : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1 && $urandom_range(0, 2) == 0) f3 = f3 | 3'b100;
      do_access(1'($urandom), f3, 18'($urandom_range(0, 255)), $urandom, bit'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    idle(1);

    // Reset during the write cycle of a halfword store
    sh_old = ref_mem[4];
    bus.req = 1'b1; bus.isStore = 1'b1; bus.funct3 = 3'b001; bus.byteAddr = 18'h0012;
    bus.storeData = 32'h0000_5A5A;
    @(posedge clk);
    #1 bus.req = 1'b0;
    seen_wr = 0; n = 0;
    while (!seen_wr && n < 6) begin
      @(negedge clk);
      n++;
      if (bus.memRW) seen_wr = 1;
    end
    check_eq("sh_reached_wr", seen_wr, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_memrw", bus.memRW, 1'b0);
    check_eq("mid_rst_busy", bus.busy, 1'b0);
    check_eq("mid_rst_done", bus.done, 1'b0);
    check_eq("mid_rst_fault", bus.fault, 1'b0);
    check_eq("mid_rst_load", bus.loadData, 32'h0);
    check_eq("mid_rst_addr", bus.memAddr, 32'h0);
    check_eq("mid_rst_memw", bus.memDataW, 32'h0);
    exp_load = 32'h0;
    exp_memw = 32'h0;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_no_done", bus.done, 1'b0);
    end
    check_eq("sh_aborted_mem", mem[4], sh_old);
    rst_n = 1'b1;
    do_access(1'b0, 3'b010, 18'h0010, 32'h0, 1'b0);
    check_eq("lw_after_rst", bus.loadData, sh_old);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter addrW, default 16: data-memory word-address width.
REQ-002 sysCLK  in  1: rising-edge clock.
REQ-003 resetN  in  1: reset, asynchronous, active-low.
REQ-004 req  in  1: access request, sampled only when busy=0.
REQ-005 isStore  in  1: 1=store, 0=load; sampled with req.
REQ-006 funct3  in  3: RV32I width code; sampled with req.
REQ-007 byteAddr  in  addrW+2: byte address; sampled with req.
REQ-008 storeData  in  32: store source (rs2); sampled with req.
REQ-009 busy  out  1: access in progress.
REQ-010 done  out  1: one-cycle completion pulse.
REQ-011 fault  out  1: valid with done; 1 = misaligned or illegal funct3.
REQ-012 loadData  out  32: extended load result.
REQ-013 memAddr  out  addrW: word address to data memory.
REQ-014 memDataW  out  32: write word to data memory.
REQ-015 memRW  out  1: data-memory write enable.
REQ-016 memDataR  in  32: data-memory read word, valid the cycle after memAddr is captured on a sysCLK edge.

Function
REQ-017 States IDLE, RD, MRG, DAT, WR; busy=1 in every state except IDLE.
REQ-018 In IDLE with req=1, the unit latches isStore, funct3, byteAddr and storeData at the rising edge; memAddr = latched byteAddr[addrW+1:2] from the next cycle onward.
REQ-019 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW.
REQ-020 Halfword access needs byteAddr[0]=0; word access needs byteAddr[1:0]=00.
REQ-021 An illegal or misaligned request stays in IDLE, performs no memory access, and produces done=1 and fault=1 in the next cycle.
REQ-022 Load path: IDLE->RD->DAT->IDLE; at the DAT->IDLE edge loadData is updated and done=1 (fault=0) in the following cycle; latency is req edge to done = 3 cycles.
REQ-023 SW path: IDLE->WR->IDLE; memDataW = storeData during WR; done=1 in the cycle after WR; latency = 2 cycles.
REQ-024 SB/SH path (read-modify-write): IDLE->RD->MRG->WR->IDLE.
REQ-025 In MRG, memDataR has the addressed lane replaced by storeData[7:0] (SB) or storeData[15:0] (SH) and the result is registered into memDataW; the other bytes are unchanged; latency = 4 cycles.
REQ-026 Lanes are little-endian: byte k = bits [8k+7:8k], k = byteAddr[1:0]; half = bits [15:0] if byteAddr[1]=0, else [31:16].
REQ-027 LB/LH sign-extend from the lane MSB; LBU/LHU zero-extend; LW passes the word unmodified.
REQ-028 memRW=1 only in state WR, decoded from state so it deasserts together with the state register.
REQ-029 memAddr and memDataW hold their values between accesses.
REQ-030 loadData changes only on load completion; stores and faults leave it unchanged.
REQ-031 req while busy=1 is ignored, with no queueing and no error.
REQ-032 A new req may be accepted in the same cycle that done=1 (back-to-back issue).
REQ-033 done and fault are registered; both are 0 in every cycle except the completion cycle.

Reset
REQ-034 resetN=0 asynchronously forces IDLE, busy=0, done=0, fault=0, loadData=0, memAddr=0, memDataW=0 and memRW=0.
REQ-035 Reset mid-access, including during WR, aborts the access with no done pulse; memory contents written before the reset edge remain.
REQ-036 The first req is accepted at the first rising edge after resetN deasserts.

Verification
REQ-037 LB at byteAddr 0x0003 with word[0]=0x80FF1234 -> after 3 cycles done=1, fault=0, loadData=0xFFFFFF80; the same access with LBU -> 0x00000080.
REQ-038 SB storeData=0x000000AB at byteAddr 0x0005 with word[1]=0x11223344 -> memRW=1 for exactly one cycle with memDataW=0x1122AB44; done after 4 cycles.
REQ-039 LH at byteAddr 0x0001, then SW at 0x0006 -> each gives done=1 and fault=1 one cycle after req, memRW never asserts, and loadData is unchanged.
REQ-040 SW 0xDEADBEEF at 0x0008, next req LW at 0x0008 in the done cycle -> loadData=0xDEADBEEF 3 cycles later; a req pulsed while busy has no effect.
REQ-041 resetN asserted during WR of an SH -> memRW drops immediately, no done pulse, all outputs are 0, and the next LW completes normally.
